vblank_update_arbiter: RTL
==========================

// Module: vblank_update_arbiter
// PURPOSE
//  Round-robin arbiter sharing one game-state update port (sprite position/score RAM) among
//  NREQ requesters, granting only inside the vertical blanking window from the VGA timing
//  block, so visible-frame state never tears. Sits between game logic and vga_timing (vblnk in).
//  Counts frames and flags requesters still holding the port when the visible area starts.
// PARAMETERS
//  NREQ      4    number of requesters (2..16)
//  FCNT_W    16   frame counter width
//  MAX_HOLD  64   max grant length in cycles (used only with FRAME_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1              pixel clock
//  rst        in   1              synchronous reset, active high
//  vblnk      in   1              vertical blank from vga_timing, registered, clk domain
//  req        in   NREQ           level request per requester, held until granted+done
//  done       in   NREQ           1-cycle completion strobe from granted requester
//  gnt        out  NREQ           one-hot grant, registered
//  gnt_id     out  $clog2(NREQ)   index of current/last grant
//  busy       out  1              1 while any gnt bit is high
//  frame_cnt  out  FCNT_W         blank windows opened since reset, wraps to 0
//  overrun    out  1              1-cycle pulse: vblnk fell while a grant was active
//  timeout    out  1              1-cycle pulse: grant force-released (0 without macro)
// BEHAVIOUR
//  Reset: gnt=0, gnt_id=0, busy=0, frame_cnt=0, overrun=0, timeout=0, rr_ptr=0,
//   state=WAIT_WIN, vblnk_q=1 (reset released mid-blank does NOT open a window).
//  vblnk_q = vblnk delayed 1 cycle; rise = vblnk & ~vblnk_q; fall = ~vblnk & vblnk_q.
//  FSM states WAIT_WIN, ARB, GRANT:
//  - WAIT_WIN: gnt=0. On rise -> ARB, frame_cnt <= frame_cnt+1 (wrap).
//  - ARB: if ~vblnk -> WAIT_WIN. Else if |req: winner = first set req at index rr_ptr,
//    rr_ptr+1, ... mod NREQ; next cycle gnt[winner]=1, gnt_id=winner, busy=1 -> GRANT.
//    No req: stay. Grant latency: req seen in ARB cycle t -> gnt high at t+1.
//  - GRANT: release when done[gnt_id]=1 OR req[gnt_id]=0 (dropped request = done).
//    Release at cycle t: gnt=0, busy=0 at t+1; rr_ptr <= gnt_id+1 mod NREQ; next state
//    ARB if vblnk=1 at t else WAIT_WIN. Next grant earliest t+2 (1 idle cycle between grants).
//  - done bits of non-granted requesters ignored; done while state!=GRANT ignored.
//  Window close: grant in flight is never revoked by vblnk fall; on fall in GRANT
//   overrun pulses 1 cycle; holder keeps port until release, then WAIT_WIN.
//  Simultaneous release + rise: impossible to matter - release goes to ARB/WAIT_WIN by vblnk
//   at t; rise in WAIT_WIN still counted (rise in GRANT/ARB does not bump frame_cnt: window
//   already open by construction).
//  Fairness: requester just released is lowest priority next round; any req held across
//   windows is granted within NREQ grants.
//  gnt_id keeps last winner after release; only meaningful while busy=1.
// CONFIGURATION
//  FRAME_ARB_TIMEOUT_EN defined: hold counter clears on grant, +1 each GRANT cycle; if no
//   release by MAX_HOLD cycles of gnt high, force release exactly as a done (rr_ptr advances)
//   and timeout pulses 1 cycle with gnt falling. Not defined: no counter, timeout tied 0,
//   grant held indefinitely.
// TESTING (NREQ=4, MAX_HOLD=64)
//  1 rst, vblnk=0, req=4'b1111 for 100 cycles -> gnt=0, frame_cnt=0; rst released with
//    vblnk=1 -> no grant until next vblnk rise.
//  2 vblnk rise, req=4'b1010, done 5 cycles after each grant -> gnt 0010 then 1000, 1 idle
//    cycle between, frame_cnt=1, rr_ptr ends 0.
//  3 req=4'b1111 held, done 3 cycles after each grant, 3 windows -> order 0,1,2,3,0,1,...
//    continues across windows; frame_cnt=3.
//  4 grant req 2, drop vblnk while held, done 10 cycles later -> overrun 1 pulse at fall,
//    gnt[2] stays until done, then WAIT_WIN, no new grant until next rise.
//  5 req[1] deasserted mid-grant without done -> gnt=0 next cycle, rr_ptr=2.
//  6 macro on: grant req 0, never done -> gnt[0] high exactly 64 cycles, timeout pulse,
//    next grant to req 1 if pending; macro off: gnt[0] holds, timeout=0.
//  7 rst asserted in GRANT -> next cycle all outputs 0, state WAIT_WIN.

Source files
------------

// File: rtl/vblank_update_arbiter_if.sv
// Request/grant bundle between game-logic requesters and vblank_update_arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface vblank_update_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy
  );
endinterface

// File: rtl/vblank_update_arbiter.sv
// Round-robin owner of the game-state update port, granting only inside vertical blank.
// Define FRAME_ARB_TIMEOUT_EN to force-release a grant after MAX_HOLD cycles.
module vblank_update_arbiter #(
  parameter int NREQ     = 4,
  parameter int FCNT_W   = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vblnk,
  vblank_update_arbiter_if.slave bus,
  output logic [FCNT_W-1:0]      o_frame_cnt,
  output logic                   o_overrun,
  output logic                   o_timeout
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_WAIT_WIN,
    S_ARB,
    S_GRANT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vblnk_q;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_rr_ptr_nxt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [IDW-1:0]    r_gnt_id;
  logic [IDW-1:0]    w_gnt_id_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [FCNT_W-1:0] w_frame_cnt_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;

  logic              w_rise;
  logic              w_fall;
  logic              w_found;
  logic [IDW-1:0]    w_winner;
  logic [IDW-1:0]    w_idx;
  logic              w_normal_rel;
  logic              w_force;
  logic              w_release;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  assign w_rise = i_vblnk & ~r_vblnk_q;
  assign w_fall = ~i_vblnk & r_vblnk_q;

  // A requester that drops its level request is treated exactly like one that strobed done.
  assign w_normal_rel = bus.done[r_gnt_id] | ~bus.req[r_gnt_id];
  assign w_release    = w_normal_rel | w_force;

`ifdef FRAME_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == S_GRANT) begin
      r_hold <= r_hold + HOLD_W'(1);
    end else begin
      r_hold <= '0;
    end
  end

  assign w_force = (r_state == S_GRANT) && (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
  logic w_unused_hold;
  assign w_unused_hold = ^MAX_HOLD;
  assign w_force       = 1'b0;
`endif

  // Scan starts at the round-robin pointer so the last holder is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = wrap_add(r_rr_ptr, i);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_busy_nxt      = r_busy;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_frame_cnt_nxt = r_frame_cnt;
    w_overrun_nxt   = 1'b0;
    w_timeout_nxt   = 1'b0;
    unique case (r_state)
      S_WAIT_WIN: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_rise) begin
          w_state_nxt     = S_ARB;
          w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
        end
      end
      S_ARB: begin
        if (!i_vblnk) begin
          w_state_nxt = S_WAIT_WIN;
        end else if (w_found) begin
          w_gnt_nxt    = NREQ'(1) << w_winner;
          w_gnt_id_nxt = w_winner;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_GRANT;
        end
      end
      S_GRANT: begin
        // The window closing never revokes a grant; it is only reported.
        w_overrun_nxt = w_fall;
        if (w_release) begin
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_rr_ptr_nxt  = wrap_add(r_gnt_id, 1);
          w_state_nxt   = i_vblnk ? S_ARB : S_WAIT_WIN;
          w_timeout_nxt = w_force & ~w_normal_rel;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_WIN;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // vblnk_q resets high so releasing reset in the middle of a blank opens no window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_WIN;
      r_vblnk_q   <= 1'b1;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vblnk_q   <= i_vblnk;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_overrun   <= w_overrun_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_overrun   = r_overrun;
  assign o_timeout   = r_timeout;
endmodule
